// File: rtl/spi_temp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_temp_pkg
// Description : Shared types and constants for the SPI temperature-sensor
//               responder: FSM state encoding, command opcodes, and the
//               default frame geometry agreed with the temp controller.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_temp_pkg;

    // Frame geometry shared with the controller side of the link.
    localparam int DEF_CMD_BITS  = 8;
    localparam int DEF_DATA_BITS = 16;

    // Command opcodes understood by the responder.
    localparam logic [7:0] OP_READ_TEMP = 8'h01;
    localparam logic [7:0] OP_READ_ID   = 8'h0F;

    // Responder frame state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // Larger of two integers; sizes the shared bit counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_sync
// Description : Multi-flop synchronizer for one asynchronous input plus
//               single-cycle rise/fall pulses derived from the synchronized
//               copy.
// Ports       : clk, rst      - system clock, synchronous active-high reset
//               async_in      - asynchronous input
//               sync_out      - synchronized level
//               rise, fall    - 1-cycle edge pulses on sync_out
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_chain;
    logic                   r_prev;

    // The chain and the edge history reset to 0. For cs this means a chip
    // select that is already low when reset lifts produces no fall edge, so
    // the frame in progress is not picked up halfway.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], async_in};
            r_prev  <= r_chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = r_chain[SYNC_STAGES-1];
    assign rise     =  sync_out & ~r_prev;
    assign fall     = ~sync_out &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_temp_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_temp_responder
// Description : SPI mode-0 responder emulating a temperature sensor. Receives
//               a CMD_BITS command on din (sampled on sclk rise), then returns
//               a DATA_BITS word on dout MSB first (changed on sclk fall).
//               All SPI inputs are oversampled in the clk domain.
// Ports       : clk, rst            - system clock, sync active-high reset
//               cs, sclk, din       - SPI inputs (async to clk)
//               dout                - SPI output, 0 when not driving
//               temp_code/temp_load - holding-register update strobe
//               cmd, cmd_valid      - last command and its update pulse
//               busy                - frame in progress
//               frame_err           - pulse on premature cs rise
// Revision    : 1.0 - initial release
// ============================================================================
module spi_temp_responder
    import spi_temp_pkg::*;
#(
    parameter int          CMD_BITS     = DEF_CMD_BITS,
    parameter int          DATA_BITS    = DEF_DATA_BITS,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [15:0] DEFAULT_CODE = 16'h0190,
    parameter logic [15:0] DEVICE_ID    = 16'h5443
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 din,
    output logic                 dout,
    input  logic [DATA_BITS-1:0] temp_code,
    input  logic                 temp_load,
    output logic [CMD_BITS-1:0]  cmd,
    output logic                 cmd_valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int C_CNT_W = $clog2(max_int(CMD_BITS, DATA_BITS));

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic w_cs_s;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sclk_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_din_s;
    logic w_unused_sclk_level;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (cs),
        .sync_out (w_cs_s),
        .rise     (w_cs_rise),
        .fall     (w_cs_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sclk),
        .sync_out (w_sclk_s),
        .rise     (w_sclk_rise),
        .fall     (w_sclk_fall)
    );

    // Only sclk edges matter; the level itself is not used.
    assign w_unused_sclk_level = w_sclk_s;

    // din only needs a level, so it gets a bare synchronizer chain of the
    // same depth, keeping it aligned with the sclk edge pulses.
    logic [SYNC_STAGES-1:0] r_din_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_sync <= '0;
        end else begin
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], din};
        end
    end

    assign w_din_s = r_din_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic                  r_armed;
    logic [C_CNT_W-1:0]    r_bit_cnt;
    logic [CMD_BITS-2:0]   r_cmd_sr;
    logic [DATA_BITS-1:0]  r_shadow;
    logic [DATA_BITS-1:0]  r_holding;

    // The command word as it will look once the current din bit is shifted
    // in; used on the final command rise so cmd and the snapshot select see
    // the complete command in the same cycle.
    logic [CMD_BITS-1:0]   w_cmd_next;
    logic [DATA_BITS-1:0]  w_snapshot;

    assign w_cmd_next = {r_cmd_sr, w_din_s};

    // Snapshot reads r_holding before any same-cycle temp_load takes
    // effect, so a coincident load lands in the next frame, not this one.
    always_comb begin
        w_snapshot = '0;
        if (w_cmd_next == CMD_BITS'(OP_READ_TEMP)) begin
            w_snapshot = r_holding;
        end else if (w_cmd_next == CMD_BITS'(OP_READ_ID)) begin
            w_snapshot = DATA_BITS'(DEVICE_ID);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_armed   <= 1'b0;
            r_bit_cnt <= '0;
            r_cmd_sr  <= '0;
            r_shadow  <= '0;
            r_holding <= DATA_BITS'(DEFAULT_CODE);
            dout      <= 1'b0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;

            if (temp_load) begin
                r_holding <= temp_code;
            end

            if (w_cs_s) begin
                r_armed <= 1'b1;
            end

            if (w_cs_rise) begin
                // cs rise takes priority over any sclk edge in the same cycle.
                r_state   <= IDLE;
                busy      <= 1'b0;
                dout      <= 1'b0;
                r_armed   <= 1'b1;
                frame_err <= (r_state == CMD) || (r_state == DATA);
            end else if (!w_cs_s) begin
                // Edges while cs is high are glitches and never reach here.
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall && r_armed) begin
                            r_state   <= CMD;
                            r_bit_cnt <= '0;
                            busy      <= 1'b1;
                        end
                    end

                    CMD: begin
                        if (w_sclk_rise) begin
                            r_cmd_sr <= w_cmd_next[CMD_BITS-2:0];
                            if (r_bit_cnt == C_CNT_W'(CMD_BITS - 1)) begin
                                cmd       <= w_cmd_next;
                                cmd_valid <= 1'b1;
                                r_shadow  <= w_snapshot;
                                r_bit_cnt <= '0;
                                r_state   <= DATA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
                            end
                        end
                    end

                    DATA: begin
                        if (w_sclk_fall) begin
                            dout     <= r_shadow[DATA_BITS-1];
                            r_shadow <= r_shadow << 1;
                        end
                        if (w_sclk_rise) begin
                            if (r_bit_cnt == C_CNT_W'(DATA_BITS - 1)) begin
                                r_state <= DONE;
                                dout    <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + C_CNT_W'(1);
                            end
                        end
                    end

                    DONE: begin
                        dout <= 1'b0;
                    end

                    default: begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        dout    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_temp_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_temp_responder
// Description : Self-checking bench for spi_temp_responder. Drives SPI mode-0
//               frames at sclk = clk/16 and compares the returned words with
//               a behavioural model of the sensor (holding value, opcode map).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_temp_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        sclk;
    logic        din;
    logic        dout;
    logic [15:0] temp_code;
    logic        temp_load;
    logic [7:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: the sensor's current temperature code.
    logic [15:0] model_hold = 16'h0190;

    // Event counters observed from the DUT outputs.
    int          cv_cnt  = 0;
    int          fe_cnt  = 0;
    logic [7:0]  cv_last = 8'h00;

    spi_temp_responder dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .sclk      (sclk),
        .din       (din),
        .dout      (dout),
        .temp_code (temp_code),
        .temp_load (temp_load),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            cv_cnt  = cv_cnt + 1;
            cv_last = cmd;
        end
        if (frame_err === 1'b1) begin
            fe_cnt = fe_cnt + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] expected_word(input logic [7:0] c);
        if (c == 8'h01) return model_hold;
        if (c == 8'h0F) return 16'h5443;
        return 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk period: present din, sample dout just before the rise.
    task automatic bit_cycle(input logic d, output logic q);
        din = d;
        wait_clks(8);
        q = dout;
        sclk = 1'b1;
        wait_clks(8);
        sclk = 1'b0;
    endtask

    task automatic load_temp(input logic [15:0] v);
        temp_code = v;
        temp_load = 1'b1;
        wait_clks(1);
        temp_load = 1'b0;
        model_hold = v;
        wait_clks(1);
    endtask

    // Drives one frame. ncmd/ndata shorten it for abort tests, nextra adds
    // sclk pulses after the data word; inject pulses temp_load on the cycle
    // the final command rise is acted on.
    task automatic run_frame(input logic [7:0] c, input int ncmd, input int ndata,
                             input int nextra, input bit inject,
                             input logic [15:0] inj_val, output logic [15:0] rx);
        logic q;
        rx = '0;
        cs = 1'b0;
        for (int i = 0; i < ncmd; i++) begin
            if (inject && i == 7) begin
                din = c[7-i];
                wait_clks(8);
                sclk = 1'b1;
                wait_clks(2);
                temp_code = inj_val;
                temp_load = 1'b1;
                wait_clks(1);
                temp_load = 1'b0;
                check("snapshot_cycle_cmd_valid", cmd_valid, 1);
                wait_clks(5);
                sclk = 1'b0;
            end else begin
                bit_cycle(c[7-i], q);
                if (i == 2) check("busy_in_frame", busy, 1);
            end
        end
        for (int j = 0; j < ndata + nextra; j++) begin
            bit_cycle(1'($urandom_range(0, 1)), q);
            if (j < ndata) rx = {rx[14:0], q};
            else check("done_dout_zero", q, 0);
        end
        wait_clks(8);
        cs = 1'b1;
        wait_clks(8);
    endtask

    task automatic full_check(input logic [7:0] c, input string tag);
        int          cv0;
        int          fe0;
        logic [15:0] rx;
        logic [15:0] e;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        e   = expected_word(c);
        run_frame(c, 8, 16, 0, 1'b0, 16'h0, rx);
        check({tag, "_data"}, rx, e);
        check({tag, "_cmd_valid_count"}, cv_cnt - cv0, 1);
        check({tag, "_cmd"}, cv_last, c);
        check({tag, "_no_frame_err"}, fe_cnt - fe0, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        logic [15:0] rx;
        logic [7:0]  c;
        logic        q;
        int          cv0;
        int          fe0;

        rst = 1'b1; cs = 1'b1; sclk = 1'b0; din = 1'b0;
        temp_code = 16'h0; temp_load = 1'b0;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(10);

        // Reset state
        check("reset_dout", dout, 0);
        check("reset_cmd", cmd, 0);
        check("reset_busy", busy, 0);
        check("reset_cmd_valid_count", cv_cnt, 0);
        check("reset_frame_err_count", fe_cnt, 0);

        // Default holding value, then loaded value and the opcode map
        full_check(8'h01, "default_temp");
        load_temp(16'h01F4);
        full_check(8'h01, "loaded_temp");
        full_check(8'h0F, "read_id");
        full_check(8'hAA, "unknown_cmd");

        // temp_load in the exact snapshot cycle: old value this frame
        cv0 = cv_cnt;
        run_frame(8'h01, 8, 16, 0, 1'b1, 16'h0300, rx);
        check("snapshot_old_value", rx, 16'h01F4);
        check("snapshot_cmd_valid_count", cv_cnt - cv0, 1);
        model_hold = 16'h0300;
        full_check(8'h01, "after_snapshot_load");

        // Abort after 5 command bits
        cv0 = cv_cnt; fe0 = fe_cnt;
        run_frame(8'h01, 5, 0, 0, 1'b0, 16'h0, rx);
        check("abort_cmd_frame_err", fe_cnt - fe0, 1);
        check("abort_cmd_busy", busy, 0);
        check("abort_cmd_dout", dout, 0);
        check("abort_cmd_no_cmd_valid", cv_cnt - cv0, 0);
        full_check(8'h0F, "after_cmd_abort");

        // Abort after 7 data bits
        fe0 = fe_cnt;
        run_frame(8'h0F, 8, 7, 0, 1'b0, 16'h0, rx);
        check("abort_data_partial", rx[6:0], 7'(16'h5443 >> 9));
        check("abort_data_frame_err", fe_cnt - fe0, 1);
        check("abort_data_busy", busy, 0);
        check("abort_data_dout", dout, 0);
        full_check(8'h01, "after_data_abort");

        // Reset mid-DATA with cs held low; the rest of the frame is ignored
        c = 8'h0F;
        cs = 1'b0;
        for (int i = 0; i < 8; i++) bit_cycle(c[7-i], q);
        for (int i = 0; i < 4; i++) bit_cycle(1'b0, q);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        model_hold = 16'h0190;
        check("midreset_cmd", cmd, 0);
        cv0 = cv_cnt; fe0 = fe_cnt;
        for (int i = 0; i < 12; i++) begin
            bit_cycle(1'($urandom_range(0, 1)), q);
            check("midreset_dout", q, 0);
        end
        check("midreset_busy", busy, 0);
        check("midreset_no_cmd_valid", cv_cnt - cv0, 0);
        wait_clks(8);
        cs = 1'b1;
        wait_clks(8);
        check("midreset_no_frame_err", fe_cnt - fe0, 0);
        full_check(8'h01, "after_midreset");

        // Extra sclk pulses after the data word
        fe0 = fe_cnt;
        run_frame(8'h01, 8, 16, 4, 1'b0, 16'h0, rx);
        check("extra_sclk_data", rx, model_hold);
        check("extra_sclk_no_frame_err", fe_cnt - fe0, 0);
        check("extra_sclk_busy", busy, 0);

        // Randomized frames against the model
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) load_temp(16'($urandom));
            case ($urandom_range(0, 2))
                0:       c = 8'h01;
                1:       c = 8'h0F;
                default: c = 8'($urandom);
            endcase
            full_check(c, "random_frame");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
